sb_config_loader: RTL

//  Bitstream loader for a daisy-chained column of switch-box tiles. Accepts config words from a host
//  (valid/ready), serialises them LSB-first onto the tile scan chain (prog_in/prog_en), and captures the

---
 rtl/sb_config_loader_pkg.sv | 7 +
 rtl/sb_config_loader_serializer.sv | 50 +++++
 rtl/sb_config_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/sb_config_loader_pkg.sv
// sb_config_loader_pkg: shared FSM states and default geometry for the config loader
package sb_config_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam int DEF_NUM_TILES     = 4;
  localparam int DEF_BITS_PER_TILE = 32;
  localparam int DEF_WORD_W        = 32;
endpackage

// File: rtl/sb_config_loader_serializer.sv
// sb_config_loader_serializer: word-to-bit shifter with one hold slot so words stream without bubbles
module sb_config_loader_serializer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         en,
  input  logic         shift,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_bit,
  output logic         out_valid
);
  localparam int IW = $clog2(W);
  logic [W-1:0] sh, hold;
  logic [IW-1:0] idx;
  logic sh_full, hold_full, acc, take, last;
  assign in_ready  = en && !hold_full;
  assign acc       = in_valid && in_ready;
  assign take      = shift && sh_full;
  assign last      = idx == IW'(W-1);
  assign out_bit   = sh[0];
  assign out_valid = sh_full;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      sh        <= '0;
      hold      <= '0;
      idx       <= '0;
      sh_full   <= 1'b0;
      hold_full <= 1'b0;
    end else begin
      if (take && !last) begin
        sh  <= sh >> 1;
        idx <= idx + 1'b1;
      end else if (take || !sh_full) begin
        // shifter frees up this edge: refill from hold first, else straight from the host
        sh      <= hold_full ? hold : in_data;
        idx     <= '0;
        sh_full <= hold_full || acc;
      end
      if (take && last) hold_full <= 1'b0;
      else if (acc && sh_full) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/sb_config_loader.sv
// sb_config_loader: serialises host words onto the switch-box scan chain and captures readback words
module sb_config_loader
  import sb_config_loader_pkg::*;
#(
  parameter int NUM_TILES     = DEF_NUM_TILES,
  parameter int BITS_PER_TILE = DEF_BITS_PER_TILE,
  parameter int WORD_W        = DEF_WORD_W,
  localparam int CHAIN_LEN    = NUM_TILES * BITS_PER_TILE,
  localparam int CW           = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_loaded,
  output logic [CW-1:0]     bit_count
);
  localparam int NUM_WORDS = CHAIN_LEN / WORD_W;
  localparam int WCW       = $clog2(NUM_WORDS + 1);
  localparam int RCW       = $clog2(WORD_W);
  state_t state, state_n;
  logic [WCW-1:0] words;
  logic [CW-1:0] caps;
  logic [RCW-1:0] rd_cnt;
  logic [WORD_W-1:0] rd_sr;
  logic ser_bit, ser_valid, go, stop, cap, shifting, cap_last, word_end;
  assign busy     = state == LOAD;
  assign go       = state == IDLE && start && !abort;
  assign stop     = busy && abort;
  assign cap      = busy && prog_en && !abort;
  assign shifting = busy && !abort && ser_valid;
  assign cap_last = caps == CW'(CHAIN_LEN - 1);
  assign word_end = rd_cnt == RCW'(WORD_W - 1);
  sb_config_loader_serializer #(.W(WORD_W)) u_ser (
    .clk      (prog_clk),
    .rst      (prog_rst),
    .flush    (stop),
    .en       (busy && words < WCW'(NUM_WORDS)),
    .shift    (busy && !abort),
    .in_data  (wr_data),
    .in_valid (wr_valid),
    .in_ready (wr_ready),
    .out_bit  (ser_bit),
    .out_valid(ser_valid)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? LOAD : IDLE;
      LOAD:    state_n = abort ? IDLE : (cap && cap_last) ? DONE : LOAD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) begin
      state      <= IDLE;
      prog_in    <= 1'b0;
      prog_en    <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      cfg_loaded <= 1'b0;
      bit_count  <= '0;
      words      <= '0;
      caps       <= '0;
      rd_cnt     <= '0;
      rd_sr      <= '0;
    end else begin
      state    <= state_n;
      prog_en  <= shifting;
      done     <= cap && cap_last;
      rd_valid <= cap && word_end;
      if (shifting) begin
        prog_in   <= ser_bit;
        bit_count <= bit_count + 1'b1;
      end
      if (wr_valid && wr_ready) words <= words + 1'b1;
      // prog_en marks a bit entering the chain, so the chain's tail bit is valid on the same edge
      if (cap) begin
        rd_sr  <= {prog_out, rd_sr[WORD_W-1:1]};
        caps   <= caps + 1'b1;
        rd_cnt <= word_end ? '0 : rd_cnt + 1'b1;
        if (word_end) rd_data <= {prog_out, rd_sr[WORD_W-1:1]};
        if (cap_last) cfg_loaded <= 1'b1;
      end
      if (stop) cfg_loaded <= 1'b0;
      if (go) begin
        cfg_loaded <= 1'b0;
        bit_count  <= '0;
        words      <= '0;
        caps       <= '0;
        rd_cnt     <= '0;
        rd_sr      <= '0;
      end
    end
  end
endmodule
